// File: rtl/wb_arbiter_if.sv
// rtl/wb_arbiter_if.sv - bus bundle for the write-back arbiter (optional bypass ports under WB_BYPASS_EN)
interface wb_arbiter_if #(
    parameter int pw = 4
);
    logic          alu_valid;
    logic          alu_ready;
    logic [pw-1:0] alu_addr;
    logic [7:0]    alu_data;
    logic          ld_issue;
    logic          ld_ready;
    logic [pw-1:0] ld_dst;
    logic          mem_valid;
    logic [7:0]    mem_data;
    logic [pw-1:0] rd_addrA;
    logic [pw-1:0] rd_addrB;
    logic          hazard;
    logic          rf_wr_en;
    logic [pw-1:0] rf_wr_addr;
    logic [7:0]    rf_dat;
    logic          err;
`ifdef WB_BYPASS_EN
    logic [7:0]    datA_in;
    logic [7:0]    datB_in;
    logic [7:0]    fwdA;
    logic [7:0]    fwdB;
`endif

    modport slave (
        input  alu_valid, alu_addr, alu_data, ld_issue, ld_dst, mem_valid, mem_data,
        input  rd_addrA, rd_addrB,
`ifdef WB_BYPASS_EN
        input  datA_in, datB_in,
        output fwdA, fwdB,
`endif
        output alu_ready, ld_ready, hazard, rf_wr_en, rf_wr_addr, rf_dat, err
    );

    modport master (
        output alu_valid, alu_addr, alu_data, ld_issue, ld_dst, mem_valid, mem_data,
        output rd_addrA, rd_addrB,
`ifdef WB_BYPASS_EN
        output datA_in, datB_in,
        input  fwdA, fwdB,
`endif
        input  alu_ready, ld_ready, hazard, rf_wr_en, rf_wr_addr, rf_dat, err
    );
endinterface

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - register-file write-back arbiter: load FIFO, ALU skid, hazard detect
// Optional operand forwarding from the registered write enabled by WB_BYPASS_EN.
module wb_arbiter #(
    parameter int pw = 4
) (
    input  logic        clk,
    input  logic        reset,
    wb_arbiter_if.slave bus
);
    logic [pw-1:0] r_fifo [4];
    logic [1:0]    r_wptr;
    logic [1:0]    r_rptr;
    logic [2:0]    r_count;
    logic          r_skid_valid;
    logic [pw-1:0] r_skid_addr;
    logic [7:0]    r_skid_data;
    logic          r_wr_en;
    logic [pw-1:0] r_wr_addr;
    logic [7:0]    r_dat;
    logic          r_err;

    logic          w_ld_ready;
    logic          w_push;
    logic          w_pop;
    logic          w_alu_acc;
    logic          w_sel_mem;
    logic          w_sel_skid;
    logic          w_sel_alu;
    logic          w_skid_load;
    logic          w_hazard;
    logic [3:0]    w_ent_valid;

    always_comb begin
        w_ld_ready  = (r_count < 3'd4);
        w_push      = bus.ld_issue && w_ld_ready;
        w_pop       = bus.mem_valid && (r_count != 3'd0);
        w_alu_acc   = bus.alu_valid && !r_skid_valid;
        w_sel_mem   = w_pop;
        w_sel_skid  = !w_pop && r_skid_valid;
        w_sel_alu   = !w_pop && !r_skid_valid && w_alu_acc;
        w_skid_load = w_pop && w_alu_acc;
    end

    // An entry is live when its distance from the read pointer is below the count.
    for (genvar gi = 0; gi < 4; gi++) begin : g_ent
        logic [1:0] w_offs;
        assign w_offs          = 2'(gi) - r_rptr;
        assign w_ent_valid[gi] = ({1'b0, w_offs} < r_count);
    end

    always_comb begin
        w_hazard = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (w_ent_valid[i] && ((r_fifo[i] == bus.rd_addrA) || (r_fifo[i] == bus.rd_addrB) ||
                                   (bus.alu_valid && (r_fifo[i] == bus.alu_addr)))) begin
                w_hazard = 1'b1;
            end
        end
        if (r_skid_valid && ((r_skid_addr == bus.rd_addrA) || (r_skid_addr == bus.rd_addrB))) begin
            w_hazard = 1'b1;
        end
`ifndef WB_BYPASS_EN
        if (r_wr_en && ((r_wr_addr == bus.rd_addrA) || (r_wr_addr == bus.rd_addrB))) begin
            w_hazard = 1'b1;
        end
`endif
    end

    // Storage only; liveness is tracked by the pointers, so no reset is needed here.
    always_ff @(posedge clk) begin
        if (!reset && w_push) begin
            r_fifo[r_wptr] <= bus.ld_dst;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr       <= 2'd0;
            r_rptr       <= 2'd0;
            r_count      <= 3'd0;
            r_skid_valid <= 1'b0;
            r_skid_addr  <= '0;
            r_skid_data  <= 8'd0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_dat        <= 8'd0;
            r_err        <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 2'd1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 2'd1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
            if (bus.mem_valid && (r_count == 3'd0)) begin
                r_err <= 1'b1;
            end

            r_wr_en <= w_sel_mem || w_sel_skid || w_sel_alu;
            if (w_sel_mem) begin
                r_wr_addr <= r_fifo[r_rptr];
                r_dat     <= bus.mem_data;
            end else if (w_sel_skid) begin
                r_wr_addr <= r_skid_addr;
                r_dat     <= r_skid_data;
            end else if (w_sel_alu) begin
                r_wr_addr <= bus.alu_addr;
                r_dat     <= bus.alu_data;
            end

            if (w_skid_load) begin
                r_skid_valid <= 1'b1;
                r_skid_addr  <= bus.alu_addr;
                r_skid_data  <= bus.alu_data;
            end else if (w_sel_skid) begin
                r_skid_valid <= 1'b0;
            end
        end
    end

    assign bus.alu_ready  = !r_skid_valid;
    assign bus.ld_ready   = w_ld_ready;
    assign bus.hazard     = w_hazard;
    assign bus.rf_wr_en   = r_wr_en;
    assign bus.rf_wr_addr = r_wr_addr;
    assign bus.rf_dat     = r_dat;
    assign bus.err        = r_err;

`ifdef WB_BYPASS_EN
    assign bus.fwdA = (r_wr_en && (r_wr_addr == bus.rd_addrA)) ? r_dat : bus.datA_in;
    assign bus.fwdB = (r_wr_en && (r_wr_addr == bus.rd_addrB)) ? r_dat : bus.datB_in;
`endif
endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - self-checking bench for wb_arbiter (default build, bypass disabled)
module tb_wb_arbiter;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    wb_arbiter_if #(.pw(4)) dif ();

    wb_arbiter #(.pw(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       alu_v;
        logic [3:0] alu_a;
        logic [7:0] alu_d;
        logic       ld_i;
        logic [3:0] ld_d;
        logic       mem_v;
        logic [7:0] mem_d;
        logic [3:0] ra;
        logic [3:0] rb;
        logic       e_alu_rdy;
        logic       e_ld_rdy;
        logic       e_haz;
        int         nwr;
        logic [3:0] w0a;
        logic [7:0] w0d;
        logic [3:0] w1a;
        logic [7:0] w1d;
    } vec_t;

    typedef struct {
        logic [3:0] addr;
        logic [7:0] data;
    } wr_t;

    vec_t tbl[$];
    wr_t  sb[$];

    function automatic vec_t mk(input logic av, input logic [3:0] aa, input logic [7:0] ad,
                                input logic li, input logic [3:0] ld, input logic mv,
                                input logic [7:0] md, input logic [3:0] ra, input logic [3:0] rb,
                                input logic ear, input logic elr, input logic eh, input int nwr,
                                input logic [3:0] w0a, input logic [7:0] w0d,
                                input logic [3:0] w1a, input logic [7:0] w1d);
        vec_t v;
        v.alu_v = av; v.alu_a = aa; v.alu_d = ad;
        v.ld_i = li;  v.ld_d = ld;  v.mem_v = mv; v.mem_d = md;
        v.ra = ra;    v.rb = rb;
        v.e_alu_rdy = ear; v.e_ld_rdy = elr; v.e_haz = eh;
        v.nwr = nwr;  v.w0a = w0a; v.w0d = w0d; v.w1a = w1a; v.w1d = w1d;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        dif.alu_valid = 1'b0; dif.alu_addr = '0; dif.alu_data = '0;
        dif.ld_issue  = 1'b0; dif.ld_dst   = '0;
        dif.mem_valid = 1'b0; dif.mem_data = '0;
        dif.rd_addrA  = '0;   dif.rd_addrB = '0;
    endtask

    // Every registered write must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (dif.rf_wr_en === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got write r%0d=%0h expected no write at %0t",
                         dif.rf_wr_addr, dif.rf_dat, $time);
            end else begin
                wr_t e;
                e = sb.pop_front();
                chk("sb_addr", 32'(dif.rf_wr_addr), 32'(e.addr));
                chk("sb_data", 32'(dif.rf_dat), 32'(e.data));
            end
        end
    end

`ifdef WB_BYPASS_EN
    assign dif.datA_in = 8'h00;
    assign dif.datB_in = 8'h00;
`endif

    initial begin
        checks = 0;
        errors = 0;
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wr_en", 32'(dif.rf_wr_en), 0);
        chk("rst_wr_addr", 32'(dif.rf_wr_addr), 0);
        chk("rst_dat", 32'(dif.rf_dat), 0);
        chk("rst_err", 32'(dif.err), 0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_alu_ready", 32'(dif.alu_ready), 1);
        chk("post_rst_ld_ready", 32'(dif.ld_ready), 1);
        chk("post_rst_hazard", 32'(dif.hazard), 0);

        //                av aa    ad     li ld    mv md     ra    rb   ear elr eh  n  w0a   w0d    w1a  w1d
        tbl.push_back(mk(0, 4'd0, 8'h00, 0, 4'd0, 0, 8'h00, 4'd0, 4'd0, 1, 1, 0, 0, 4'd0, 8'h00, 4'd0, 8'h00));
        tbl.push_back(mk(1, 4'd3, 8'h5A, 0, 4'd0, 0, 8'h00, 4'd0, 4'd0, 1, 1, 0, 1, 4'd3, 8'h5A, 4'd0, 8'h00));
        tbl.push_back(mk(0, 4'd0, 8'h00, 0, 4'd0, 0, 8'h00, 4'd3, 4'd0, 1, 1, 1, 0, 4'd0, 8'h00, 4'd0, 8'h00));
        tbl.push_back(mk(0, 4'd0, 8'h00, 0, 4'd0, 0, 8'h00, 4'd3, 4'd0, 1, 1, 0, 0, 4'd0, 8'h00, 4'd0, 8'h00));
        tbl.push_back(mk(0, 4'd0, 8'h00, 1, 4'd1, 0, 8'h00, 4'd0, 4'd0, 1, 1, 0, 0, 4'd0, 8'h00, 4'd0, 8'h00));
        tbl.push_back(mk(0, 4'd0, 8'h00, 1, 4'd2, 0, 8'h00, 4'd1, 4'd0, 1, 1, 1, 0, 4'd0, 8'h00, 4'd0, 8'h00));
        tbl.push_back(mk(0, 4'd0, 8'h00, 1, 4'd5, 0, 8'h00, 4'd0, 4'd2, 1, 1, 1, 0, 4'd0, 8'h00, 4'd0, 8'h00));
        tbl.push_back(mk(0, 4'd0, 8'h00, 1, 4'd7, 0, 8'h00, 4'd5, 4'd0, 1, 1, 1, 0, 4'd0, 8'h00, 4'd0, 8'h00));
        tbl.push_back(mk(0, 4'd0, 8'h00, 1, 4'd9, 0, 8'h00, 4'd7, 4'd0, 1, 0, 1, 0, 4'd0, 8'h00, 4'd0, 8'h00));
        tbl.push_back(mk(0, 4'd0, 8'h00, 1, 4'd9, 1, 8'h11, 4'd0, 4'd0, 1, 0, 0, 1, 4'd1, 8'h11, 4'd0, 8'h00));
        tbl.push_back(mk(0, 4'd0, 8'h00, 0, 4'd0, 1, 8'h22, 4'd9, 4'd0, 1, 1, 0, 1, 4'd2, 8'h22, 4'd0, 8'h00));
        tbl.push_back(mk(0, 4'd0, 8'h00, 0, 4'd0, 1, 8'h55, 4'd1, 4'd0, 1, 1, 0, 1, 4'd5, 8'h55, 4'd0, 8'h00));
        tbl.push_back(mk(0, 4'd0, 8'h00, 0, 4'd0, 1, 8'h77, 4'd7, 4'd0, 1, 1, 1, 1, 4'd7, 8'h77, 4'd0, 8'h00));
        tbl.push_back(mk(0, 4'd0, 8'h00, 0, 4'd0, 0, 8'h00, 4'd7, 4'd0, 1, 1, 1, 0, 4'd0, 8'h00, 4'd0, 8'h00));
        tbl.push_back(mk(0, 4'd0, 8'h00, 0, 4'd0, 0, 8'h00, 4'd7, 4'd0, 1, 1, 0, 0, 4'd0, 8'h00, 4'd0, 8'h00));
        tbl.push_back(mk(0, 4'd0, 8'h00, 1, 4'd4, 0, 8'h00, 4'd0, 4'd0, 1, 1, 0, 0, 4'd0, 8'h00, 4'd0, 8'h00));
        tbl.push_back(mk(1, 4'd6, 8'h9E, 0, 4'd0, 1, 8'hC3, 4'd0, 4'd0, 1, 1, 0, 2, 4'd4, 8'hC3, 4'd6, 8'h9E));
        tbl.push_back(mk(0, 4'd0, 8'h00, 0, 4'd0, 0, 8'h00, 4'd6, 4'd0, 0, 1, 1, 0, 4'd0, 8'h00, 4'd0, 8'h00));
        tbl.push_back(mk(0, 4'd0, 8'h00, 0, 4'd0, 0, 8'h00, 4'd6, 4'd0, 1, 1, 1, 0, 4'd0, 8'h00, 4'd0, 8'h00));
        tbl.push_back(mk(0, 4'd0, 8'h00, 0, 4'd0, 0, 8'h00, 4'd6, 4'd0, 1, 1, 0, 0, 4'd0, 8'h00, 4'd0, 8'h00));
        tbl.push_back(mk(0, 4'd0, 8'h00, 1, 4'd8, 0, 8'h00, 4'd0, 4'd0, 1, 1, 0, 0, 4'd0, 8'h00, 4'd0, 8'h00));
        tbl.push_back(mk(1, 4'd8, 8'h33, 0, 4'd0, 0, 8'h00, 4'd0, 4'd0, 1, 1, 1, 1, 4'd8, 8'h33, 4'd0, 8'h00));
        tbl.push_back(mk(0, 4'd0, 8'h00, 0, 4'd0, 0, 8'h00, 4'd0, 4'd0, 1, 1, 0, 0, 4'd0, 8'h00, 4'd0, 8'h00));
        tbl.push_back(mk(0, 4'd0, 8'h00, 0, 4'd0, 1, 8'h44, 4'd0, 4'd0, 1, 1, 0, 1, 4'd8, 8'h44, 4'd0, 8'h00));
        tbl.push_back(mk(0, 4'd0, 8'h00, 1, 4'd10, 0, 8'h00, 4'd0, 4'd0, 1, 1, 0, 0, 4'd0, 8'h00, 4'd0, 8'h00));
        tbl.push_back(mk(0, 4'd0, 8'h00, 1, 4'd11, 1, 8'h66, 4'd10, 4'd0, 1, 1, 1, 1, 4'd10, 8'h66, 4'd0, 8'h00));
        tbl.push_back(mk(0, 4'd0, 8'h00, 1, 4'd12, 1, 8'h67, 4'd0, 4'd11, 1, 1, 1, 1, 4'd11, 8'h67, 4'd0, 8'h00));
        tbl.push_back(mk(0, 4'd0, 8'h00, 1, 4'd13, 1, 8'h68, 4'd10, 4'd0, 1, 1, 0, 1, 4'd12, 8'h68, 4'd0, 8'h00));
        tbl.push_back(mk(0, 4'd0, 8'h00, 0, 4'd0, 1, 8'h69, 4'd13, 4'd0, 1, 1, 1, 1, 4'd13, 8'h69, 4'd0, 8'h00));
        tbl.push_back(mk(0, 4'd0, 8'h00, 0, 4'd0, 0, 8'h00, 4'd13, 4'd0, 1, 1, 1, 0, 4'd0, 8'h00, 4'd0, 8'h00));
        tbl.push_back(mk(0, 4'd0, 8'h00, 0, 4'd0, 0, 8'h00, 4'd13, 4'd0, 1, 1, 0, 0, 4'd0, 8'h00, 4'd0, 8'h00));

        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge clk);
            #1;
            dif.alu_valid = tbl[i].alu_v; dif.alu_addr = tbl[i].alu_a; dif.alu_data = tbl[i].alu_d;
            dif.ld_issue  = tbl[i].ld_i;  dif.ld_dst   = tbl[i].ld_d;
            dif.mem_valid = tbl[i].mem_v; dif.mem_data = tbl[i].mem_d;
            dif.rd_addrA  = tbl[i].ra;    dif.rd_addrB = tbl[i].rb;
            if (tbl[i].nwr > 0) sb.push_back('{addr: tbl[i].w0a, data: tbl[i].w0d});
            if (tbl[i].nwr > 1) sb.push_back('{addr: tbl[i].w1a, data: tbl[i].w1d});
            @(negedge clk);
            chk($sformatf("v%0d_alu_ready", i), 32'(dif.alu_ready), 32'(tbl[i].e_alu_rdy));
            chk($sformatf("v%0d_ld_ready", i), 32'(dif.ld_ready), 32'(tbl[i].e_ld_rdy));
            chk($sformatf("v%0d_hazard", i), 32'(dif.hazard), 32'(tbl[i].e_haz));
        end
        @(posedge clk);
        #1;
        idle_inputs();
        repeat (2) @(negedge clk);
        chk("tbl_err_clear", 32'(dif.err), 0);

        // Load return with nothing outstanding: flags error, writes nothing, sticks.
        @(posedge clk);
        #1;
        dif.mem_valid = 1'b1;
        dif.mem_data  = 8'hEE;
        @(posedge clk);
        #1;
        idle_inputs();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("err_sticky%0d", k), 32'(dif.err), 1);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("err_cleared", 32'(dif.err), 0);

        // Reset with two loads outstanding, colliding with a return and an ALU result.
        @(posedge clk);
        #1;
        dif.ld_issue = 1'b1;
        dif.ld_dst   = 4'd2;
        @(posedge clk);
        #1;
        dif.ld_dst   = 4'd3;
        @(posedge clk);
        #1;
        idle_inputs();
        dif.rd_addrA = 4'd2;
        @(negedge clk);
        chk("pend_hazard", 32'(dif.hazard), 1);
        @(posedge clk);
        #1;
        reset         = 1'b1;
        dif.mem_valid = 1'b1;
        dif.mem_data  = 8'hAA;
        dif.alu_valid = 1'b1;
        dif.alu_addr  = 4'd5;
        dif.alu_data  = 8'hBB;
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle_inputs();
        dif.rd_addrA = 4'd2;
        dif.rd_addrB = 4'd3;
        @(negedge clk);
        chk("mid_rst_wr_en", 32'(dif.rf_wr_en), 0);
        chk("mid_rst_wr_addr", 32'(dif.rf_wr_addr), 0);
        chk("mid_rst_dat", 32'(dif.rf_dat), 0);
        chk("mid_rst_hazard", 32'(dif.hazard), 0);
        chk("mid_rst_alu_ready", 32'(dif.alu_ready), 1);
        chk("mid_rst_ld_ready", 32'(dif.ld_ready), 1);
        @(posedge clk);
        #1;
        dif.mem_valid = 1'b1;
        dif.mem_data  = 8'hCC;
        @(posedge clk);
        #1;
        idle_inputs();
        repeat (2) @(negedge clk);
        chk("mid_rst_count_zero_err", 32'(dif.err), 1);
        chk("sb_drained", 32'(sb.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
